// File: rtl/dsp_pkg.sv
// -----------------------------------------------------------------------------
// dsp_pkg
// Shared definitions for the DSP48A1 MAC sequencer: sequencer state encoding,
// OPMODE accumulate-strobe values and the pipeline depth helper.
// -----------------------------------------------------------------------------
package dsp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } state_e;

  // Value driven on opmode_acc: load P from M, or accumulate M into P.
  localparam logic OPMODE_LOAD = 1'b0;
  localparam logic OPMODE_ACC  = 1'b1;

  // Register stages an operand passes through: A/B, optional M, then P.
  function automatic int pipe_depth(input int mreg);
    return 2 + ((mreg != 0) ? 1 : 0);
  endfunction

endpackage

// File: rtl/dsp_mac_sequencer_if.sv
// -----------------------------------------------------------------------------
// dsp_mac_sequencer_if
// Command, operand, result handshakes and slice control strobes of the MAC
// sequencer.
//   slave  : sequencer side (drives ready/strobes/res_valid)
//   master : job source / slice side (drives cmd, abort, op_valid, res_ready)
// -----------------------------------------------------------------------------
interface dsp_mac_sequencer_if #(
  parameter int LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic             abort;
  logic             op_valid;
  logic             op_ready;
  logic             ce_ab;
  logic             ce_m;
  logic             ce_p;
  logic             rst_p;
  logic             opmode_acc;
  logic             res_valid;
  logic             res_ready;

  modport slave (
    input  cmd_valid, cmd_len, abort, op_valid, res_ready,
    output cmd_ready, op_ready, ce_ab, ce_m, ce_p, rst_p, opmode_acc, res_valid
  );

  modport master (
    output cmd_valid, cmd_len, abort, op_valid, res_ready,
    input  cmd_ready, op_ready, ce_ab, ce_m, ce_p, rst_p, opmode_acc, res_valid
  );
endinterface

// File: rtl/dsp_token_pipe.sv
// -----------------------------------------------------------------------------
// dsp_token_pipe
// Shadows the slice data registers with valid/first/last token bits so the
// sequencer knows which register stage holds a live operand.
//   clk, rst_n     : clock, async active-low reset
//   flush_i        : synchronous clear of all token valid bits
//   in_*_i         : token entering the A/B stage (valid = operand handshake)
//   head_valid_o   : token present in the A/B stage
//   out_*_o        : token in the stage that feeds P
// -----------------------------------------------------------------------------
module dsp_token_pipe #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush_i,
  input  logic in_valid_i,
  input  logic in_first_i,
  input  logic in_last_i,
  output logic head_valid_o,
  output logic out_valid_o,
  output logic out_first_o,
  output logic out_last_o
);

  logic [STAGES-1:0] valid_q, first_q, last_q;
  logic [STAGES-1:0] valid_src, first_src, last_src;

  assign valid_src[0] = in_valid_i;
  assign first_src[0] = in_first_i;
  assign last_src[0]  = in_last_i;

  if (STAGES > 1) begin : g_shift
    assign valid_src[STAGES-1:1] = valid_q[STAGES-2:0];
    assign first_src[STAGES-1:1] = first_q[STAGES-2:0];
    assign last_src[STAGES-1:1]  = last_q[STAGES-2:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      first_q <= '0;
      last_q  <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_src;
      // Tag bits only move with a live token, mirroring the data register CE.
      for (int i = 0; i < STAGES; i++) begin
        if (valid_src[i]) begin
          first_q[i] <= first_src[i];
          last_q[i]  <= last_src[i];
        end
      end
    end
  end

  assign head_valid_o = valid_q[0];
  assign out_valid_o  = valid_q[STAGES-1];
  assign out_first_o  = first_q[STAGES-1];
  assign out_last_o   = last_q[STAGES-1];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// -----------------------------------------------------------------------------
// dsp_mac_sequencer
// Control side of a DSP48A1 MAC: accepts a job (operand-pair count), paces the
// operand stream, tracks tokens through A/B -> (M) -> P and holds res_valid
// once P contains the final sum.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave modport of dsp_mac_sequencer_if
//                cmd_valid/cmd_ready/cmd_len  job request
//                abort                        synchronous job abort
//                op_valid/op_ready            operand stream handshake
//                ce_ab/ce_m/ce_p              register clock enables
//                rst_p, opmode_acc            P clear and accumulate select
//                res_valid/res_ready          result handshake
// Parameters: LEN_W (cmd_len width), MREG (1: M stage present).
// -----------------------------------------------------------------------------
module dsp_mac_sequencer #(
  parameter int LEN_W = 8,
  parameter int MREG  = 1
) (
  input logic            clk,
  input logic            rst_n,
  dsp_mac_sequencer_if.slave bus
);
  import dsp_pkg::*;

  localparam int STAGES = pipe_depth(MREG) - 1;  // token stages ahead of P

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;
  logic             cmd_ready_q;
  logic             abort_q;

  logic abort_act, cmd_fire, op_fire;
  logic head_valid, tok_valid, tok_first, tok_last;

  // abort only matters while a job is in flight; in IDLE a command still wins.
  assign abort_act = bus.abort && (state_q != IDLE);
  assign cmd_fire  = bus.cmd_valid && cmd_ready_q && (state_q == IDLE);
  assign op_fire   = bus.op_valid && bus.op_ready;

  // NOTE: state registers use non-blocking assignment so every register
  // samples the pre-edge value of the others; blocking here would create
  // order-dependent simulation and mismatch synthesis.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      first_q     <= 1'b0;
      cmd_ready_q <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      // Registered so cmd_ready first rises one edge after reset release.
      cmd_ready_q <= (state_d == IDLE);
      abort_q     <= abort_act;
    end
  end

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          cnt_d   = bus.cmd_len;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        first_d = 1'b1;
        state_d = (cnt_q == '0) ? DONE : STREAM;
      end
      STREAM: begin
        if (op_fire) begin
          cnt_d   = cnt_q - LEN_W'(1);
          first_d = 1'b0;
          // Leave on the last handshake so the counter never wraps past zero.
          if (cnt_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (tok_valid && tok_last) state_d = DONE;
      end
      DONE: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort_act) state_d = IDLE;
  end

  dsp_token_pipe #(
    .STAGES(STAGES)
  ) u_token_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (abort_act),
    .in_valid_i  (op_fire),
    .in_first_i  (first_q),
    .in_last_i   (cnt_q == LEN_W'(1)),
    .head_valid_o(head_valid),
    .out_valid_o (tok_valid),
    .out_first_o (tok_first),
    .out_last_o  (tok_last)
  );

  // abort suppresses the operand and result handshakes in its own cycle.
  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.op_ready   = (state_q == STREAM) && !bus.abort;
  assign bus.ce_ab      = op_fire;
  assign bus.ce_m       = (MREG != 0) ? head_valid : 1'b0;
  assign bus.ce_p       = tok_valid;
  assign bus.rst_p      = (state_q == CLEAR) || abort_q;
  assign bus.opmode_acc = (tok_valid && !tok_first) ? OPMODE_ACC : OPMODE_LOAD;
  assign bus.res_valid  = (state_q == DONE) && !bus.abort;

endmodule
